// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, constants and FSM encoding for the ALU arbiter
package alu_pkg;

  localparam logic [3:0] ALU_ADD     = 4'h0;
  localparam logic [3:0] ALU_SUB     = 4'h1;
  localparam logic [3:0] ALU_MUL     = 4'h2;
  localparam logic [3:0] ALU_DIV     = 4'h3;
  localparam logic [3:0] ALU_SHL     = 4'h4;
  localparam logic [3:0] ALU_SHR     = 4'h5;
  localparam logic [3:0] ALU_OP_LAST = 4'h5;

  localparam logic [7:0] DIV0_RESULT = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - 8-bit combinational ALU: add, sub, mul, div, shift left/right
module alu
  import alu_pkg::*;
(
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic [3:0] sel_i,
  output logic [7:0] result_o,
  output logic       carry_o
);

  logic [8:0]  sum;
  logic [15:0] prod;

  assign sum  = {1'b0, a_i} + {1'b0, b_i};
  assign prod = {8'h00, a_i} * {8'h00, b_i};

  always_comb begin
    result_o = 8'h00;
    carry_o  = 1'b0;
    case (sel_i)
      ALU_ADD: begin
        result_o = sum[7:0];
        carry_o  = sum[8];
      end
      ALU_SUB: result_o = a_i - b_i;
      ALU_MUL: result_o = prod[7:0];
      // Quotient is meaningless for b == 0; the caller substitutes its own value.
      ALU_DIV: result_o = (b_i != 8'h00) ? (a_i / b_i) : 8'h00;
      ALU_SHL: result_o = {a_i[6:0], 1'b0};
      ALU_SHR: result_o = {1'b0, a_i[7:1]};
      default: result_o = 8'h00;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin sharing of one ALU between two valid/ready requesters
module alu_arbiter
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [7:0]  req_sel,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [7:0]  rsp_data,
  output logic        rsp_carry,
  output logic        rsp_err
);

  state_e      state_q, state_d;
  logic        last_grant_q;
  logic [3:0]  op_sel_q;
  logic [7:0]  op_a_q, op_b_q;
  logic        op_id_q;
  logic        rsp_id_q, rsp_carry_q, rsp_err_q;
  logic [7:0]  rsp_data_q;
  logic        rsp_carry_d, rsp_err_d;
  logic [7:0]  rsp_data_d;

  logic        grant;
  logic        accept;
  logic [3:0]  grant_sel;
  logic [7:0]  grant_a, grant_b;
  logic [7:0]  alu_result;
  logic        alu_carry;
  logic        op_illegal, op_div0;

  // On a tie the requester that did not win last time goes first.
  always_comb begin
    if (req_valid == 2'b11) grant = ~last_grant_q;
    else                    grant = req_valid[1];
  end

  assign accept    = (state_q == ST_IDLE) && !rst && (req_valid != 2'b00);
  assign req_ready = accept ? (grant ? 2'b10 : 2'b01) : 2'b00;
  assign grant_sel = grant ? req_sel[7:4]  : req_sel[3:0];
  assign grant_a   = grant ? req_a[15:8]   : req_a[7:0];
  assign grant_b   = grant ? req_b[15:8]   : req_b[7:0];

  alu u_alu (
    .a_i      (op_a_q),
    .b_i      (op_b_q),
    .sel_i    (op_sel_q),
    .result_o (alu_result),
    .carry_o  (alu_carry)
  );

  assign op_illegal = (op_sel_q > ALU_OP_LAST);
  assign op_div0    = (op_sel_q == ALU_DIV) && (op_b_q == 8'h00);

  always_comb begin
    rsp_data_d  = alu_result;
    rsp_carry_d = (op_sel_q == ALU_ADD) ? alu_carry : 1'b0;
    rsp_err_d   = 1'b0;
    if (op_illegal) begin
      rsp_data_d  = 8'h00;
      rsp_carry_d = 1'b0;
      rsp_err_d   = 1'b1;
    end else if (op_div0) begin
      rsp_data_d  = DIV0_RESULT;
      rsp_err_d   = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept)    state_d = ST_EXEC;
      ST_EXEC:                state_d = ST_RESP;
      ST_RESP: if (rsp_ready) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      op_sel_q     <= 4'h0;
      op_a_q       <= 8'h00;
      op_b_q       <= 8'h00;
      op_id_q      <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_data_q   <= 8'h00;
      rsp_carry_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_sel_q     <= grant_sel;
        op_a_q       <= grant_a;
        op_b_q       <= grant_b;
        op_id_q      <= grant;
        last_grant_q <= grant;
      end
      if (state_q == ST_EXEC) begin
        rsp_id_q    <= op_id_q;
        rsp_data_q  <= rsp_data_d;
        rsp_carry_q <= rsp_carry_d;
        rsp_err_q   <= rsp_err_d;
      end
    end
  end

  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_carry = rsp_carry_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed self-checking bench for alu_arbiter
module tb_alu_arbiter;
  import alu_pkg::*;

  logic        clk;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [7:0]  req_sel;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [7:0]  rsp_data;
  logic        rsp_carry;
  logic        rsp_err;

  int checks = 0;
  int passed = 0;
  int cyc = 0;

  alu_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_sel   (req_sel),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_carry (rsp_carry),
    .rsp_err   (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Drives one request, waits for accept then response; returns observed payload.
  task automatic run_op(input logic id, input logic [3:0] sel, input logic [7:0] a,
                        input logic [7:0] b, output logic [7:0] d, output logic c,
                        output logic e, output logic rid, output int lat,
                        output int acc_cyc, output bit ok);
    int n;
    ok = 1'b1;
    rsp_ready = 1'b1;
    if (id) begin
      req_sel[7:4] = sel; req_a[15:8] = a; req_b[15:8] = b;
    end else begin
      req_sel[3:0] = sel; req_a[7:0] = a; req_b[7:0] = b;
    end
    req_valid[id] = 1'b1;
    n = 0;
    #1;
    while (!req_ready[id] && n < 20) begin
      @(negedge clk); #1; n++;
    end
    if (!req_ready[id]) ok = 1'b0;
    acc_cyc = cyc;
    lat = 0;
    @(negedge clk);
    req_valid[id] = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk); lat++;
    end
    if (!rsp_valid) ok = 1'b0;
    d = rsp_data; c = rsp_carry; e = rsp_err; rid = rsp_id;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    req_valid = 2'b01;
    rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (req_ready !== 2'b00) $display("FAIL reset_req_ready got=%b exp=00", req_ready);
    else passed++;
    checks++;
    if ({rsp_valid, rsp_id, rsp_data, rsp_carry, rsp_err} !== 12'h000)
      $display("FAIL reset_outputs got v=%b id=%b d=%h c=%b e=%b exp all zero",
               rsp_valid, rsp_id, rsp_data, rsp_carry, rsp_err);
    else passed++;
    @(negedge clk);
    req_valid = 2'b00;
    rst = 1'b0;
  endtask

  task automatic test_add();
    logic [7:0] d; logic c, e, rid; int lat, acc; bit ok;
    run_op(1'b0, ALU_ADD, 8'hF0, 8'h20, d, c, e, rid, lat, acc, ok);
    checks++;
    if (!ok || lat != 2) $display("FAIL add_latency got=%0d exp=2 ok=%0d", lat, ok);
    else passed++;
    checks++;
    if ({d, c, e, rid} !== {8'h10, 1'b1, 1'b0, 1'b0})
      $display("FAIL add_payload got d=%h c=%b e=%b id=%b exp d=10 c=1 e=0 id=0", d, c, e, rid);
    else passed++;
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    int n;
    logic g;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rsp_ready = 1'b1;
    req_sel = {ALU_ADD, ALU_ADD};
    req_a = {8'h03, 8'h01};
    req_b = {8'h04, 8'h01};
    req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      #1;
      while (req_ready == 2'b00 && n < 10) begin
        @(negedge clk); #1; n++;
      end
      g = req_ready[1];
      checks++;
      if (req_ready !== (i[0] ? 2'b10 : 2'b01))
        $display("FAIL rr_grant round=%0d got=%b exp=%b", i, req_ready, i[0] ? 2'b10 : 2'b01);
      else passed++;
      @(negedge clk);
      n = 0;
      while (!rsp_valid && n < 10) begin
        @(negedge clk); n++;
      end
      checks++;
      if (!rsp_valid || rsp_id !== i[0] || rsp_data !== (i[0] ? 8'h07 : 8'h02))
        $display("FAIL rr_rsp round=%0d got v=%b id=%b d=%h exp v=1 id=%0d d=%h",
                 i, rsp_valid, rsp_id, rsp_data, i[0], i[0] ? 8'h07 : 8'h02);
      else passed++;
      if (g !== i[0]) ;
      @(negedge clk);
    end
    req_valid = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_ops();
    logic [3:0] sels [7] = '{ALU_DIV, ALU_DIV, ALU_MUL, ALU_SUB, ALU_SHL, ALU_SHR, 4'h9};
    logic [7:0] as   [7] = '{8'h64, 8'h2A, 8'h10, 8'h05, 8'h81, 8'h81, 8'h12};
    logic [7:0] bs   [7] = '{8'h07, 8'h00, 8'h11, 8'h07, 8'h00, 8'h00, 8'h34};
    logic [7:0] eds  [7] = '{8'h0E, 8'hFF, 8'h10, 8'hFE, 8'h02, 8'h40, 8'h00};
    logic       ees  [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic       ids  [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [7:0] d; logic c, e, rid; int lat, acc; bit ok;
    for (int i = 0; i < 7; i++) begin
      run_op(ids[i], sels[i], as[i], bs[i], d, c, e, rid, lat, acc, ok);
      checks++;
      if (!ok || d !== eds[i] || c !== 1'b0 || e !== ees[i] || rid !== ids[i])
        $display("FAIL op%0d_sel%h got d=%h c=%b e=%b id=%b exp d=%h c=0 e=%b id=%b",
                 i, sels[i], d, c, e, rid, eds[i], ees[i], ids[i]);
      else passed++;
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d; logic c, e, rid; int lat, acc1, acc2; bit ok1, ok2;
    run_op(1'b0, ALU_ADD, 8'h01, 8'h02, d, c, e, rid, lat, acc1, ok1);
    run_op(1'b1, ALU_SUB, 8'h09, 8'h03, d, c, e, rid, lat, acc2, ok2);
    checks++;
    if (!ok1 || !ok2 || (acc2 - acc1) != 3 || d !== 8'h06 || rid !== 1'b1)
      $display("FAIL back_to_back got spacing=%0d d=%h id=%b exp spacing=3 d=06 id=1",
               acc2 - acc1, d, rid);
    else passed++;
    @(negedge clk);
  endtask

  task automatic test_stall();
    int n;
    rsp_ready = 1'b0;
    req_sel[3:0] = ALU_ADD; req_a[7:0] = 8'h01; req_b[7:0] = 8'h02;
    req_valid = 2'b01;
    #1;
    checks++;
    if (req_ready !== 2'b01) $display("FAIL stall_accept got=%b exp=01", req_ready);
    else passed++;
    @(negedge clk);
    req_valid = 2'b10;
    req_sel[7:4] = ALU_SUB; req_a[15:8] = 8'h09; req_b[15:8] = 8'h03;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== 8'h03 || rsp_id !== 1'b0 || rsp_carry !== 1'b0
          || rsp_err !== 1'b0 || req_ready !== 2'b00)
        $display("FAIL stall_hold cyc=%0d got v=%b d=%h id=%b rdy=%b exp v=1 d=03 id=0 rdy=00",
                 i, rsp_valid, rsp_data, rsp_id, req_ready);
      else passed++;
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 2'b00) $display("FAIL stall_release_same_cycle got=%b exp=00", req_ready);
    else passed++;
    @(negedge clk);
    #1;
    checks++;
    if (req_ready !== 2'b10 || rsp_valid !== 1'b0)
      $display("FAIL stall_next_accept got rdy=%b v=%b exp rdy=10 v=0", req_ready, rsp_valid);
    else passed++;
    @(negedge clk);
    req_valid = 2'b00;
    n = 0;
    while (!rsp_valid && n < 10) begin
      @(negedge clk); n++;
    end
    checks++;
    if (!rsp_valid || rsp_data !== 8'h06 || rsp_id !== 1'b1)
      $display("FAIL stall_second_rsp got v=%b d=%h id=%b exp v=1 d=06 id=1", rsp_valid, rsp_data, rsp_id);
    else passed++;
    @(negedge clk);
  endtask

  task automatic test_reset_in_exec();
    int n;
    bit saw_valid;
    rsp_ready = 1'b1;
    req_sel[3:0] = ALU_ADD; req_a[7:0] = 8'hF0; req_b[7:0] = 8'h20;
    req_valid = 2'b01;
    #1;
    checks++;
    if (req_ready !== 2'b01) $display("FAIL rstexec_accept got=%b exp=01", req_ready);
    else passed++;
    @(negedge clk);
    rst = 1'b1;
    req_valid = 2'b10;
    req_sel[7:4] = ALU_SUB; req_a[15:8] = 8'h09; req_b[15:8] = 8'h03;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({rsp_valid, rsp_id, rsp_data, rsp_carry, rsp_err} !== 12'h000)
      $display("FAIL rstexec_outputs got v=%b id=%b d=%h c=%b e=%b exp all zero",
               rsp_valid, rsp_id, rsp_data, rsp_carry, rsp_err);
    else passed++;
    checks++;
    if (req_ready !== 2'b10) $display("FAIL rstexec_pending_accept got=%b exp=10", req_ready);
    else passed++;
    @(negedge clk);
    req_valid = 2'b00;
    checks++;
    if (rsp_valid !== 1'b0) $display("FAIL rstexec_exec_no_valid got=%b exp=0", rsp_valid);
    else passed++;
    saw_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 10) begin
      @(negedge clk); n++;
    end
    checks++;
    if (!rsp_valid || n != 1 || rsp_data !== 8'h06 || rsp_id !== 1'b1 || rsp_err !== 1'b0)
      $display("FAIL rstexec_rsp got v=%b wait=%0d d=%h id=%b e=%b exp v=1 wait=1 d=06 id=1 e=0",
               rsp_valid, n, rsp_data, rsp_id, rsp_err);
    else passed++;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 2'b00;
    req_sel = 8'h00;
    req_a = 16'h0000;
    req_b = 16'h0000;
    rsp_ready = 1'b0;
    test_reset();
    test_add();
    test_round_robin();
    test_ops();
    test_back_to_back();
    test_stall();
    test_reset_in_exec();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout passed=%0d total=%0d", passed, checks);
    $fatal(1);
  end

endmodule
